mc_control_unit: RTL and testbench

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/mips_ctrl_pkg.sv | 78 +++++++
 rtl/mc_control_unit_alu_decoder.sv | 26 ++
 rtl/mc_control_unit.sv | 142 ++++++++++++++
 tb/tb_mc_control_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multicycle MIPS control unit:
// state encodings, opcode/funct values, ALU codes, mux selects and the
// packed control-word bundle produced by the state decoder.
package mips_ctrl_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned STATE_W  = 4;
  localparam int unsigned SRCB_W   = 2;
  localparam int unsigned PCSRC_W  = 2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  // Opcodes (instr[31:26])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'b111;

  // ALU operand B select
  localparam logic [SRCB_W-1:0] SRCB_REG     = 2'b00;
  localparam logic [SRCB_W-1:0] SRCB_FOUR    = 2'b01;
  localparam logic [SRCB_W-1:0] SRCB_IMM     = 2'b10;
  localparam logic [SRCB_W-1:0] SRCB_IMM_SH2 = 2'b11;

  // Next-PC select
  localparam logic [PCSRC_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'b10;

  // Control word decoded from the current state
  typedef struct packed {
    logic                pc_write;
    logic                branch;
    logic                ir_write;
    logic                mem_write;
    logic                reg_write;
    logic                iord;
    logic                mem_to_reg;
    logic                reg_dst;
    logic                alu_src_a;
    logic [SRCB_W-1:0]   alu_src_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic [PCSRC_W-1:0]  pc_src;
    logic                illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mc_control_unit_alu_decoder.sv
// R-type funct to ALU operation decoder; also flags whether funct is supported.
//   funct  : instr[5:0]
//   alu_op : ALU code for the funct (ADD when unsupported)
//   legal  : 1 when funct is one of add/sub/and/or/slt
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [FUNCT_W-1:0]  funct,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                legal
);

  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control FSM (lw, sw, R-type, beq, addi, j).
//   clk, rst_n        : clock, async active-low reset
//   opcode, funct     : instruction fields from the IR
//   zero              : ALU zero flag, used combinationally in BRANCH
//   pc_en .. pc_src   : datapath controls, Moore-decoded from the state
//   illegal_op        : pulse in DECODE for unsupported instructions
//   state_dbg         : current state encoding
module mc_control_unit
  import mips_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OP_W-1:0]     opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                zero,
  output logic                pc_en,
  output logic                ir_write,
  output logic                mem_write,
  output logic                reg_write,
  output logic                iord,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                alu_src_a,
  output logic [SRCB_W-1:0]   alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [PCSRC_W-1:0]  pc_src,
  output logic                illegal_op,
  output logic [STATE_W-1:0]  state_dbg
);

  state_t              state_q;
  state_t              state_d;
  ctrl_t               ctrl;
  logic [ALU_OP_W-1:0] dec_alu_op;
  logic                funct_legal;

  // Shared funct decode: ALU code in EXECUTE, legality in DECODE
  alu_decoder u_alu_decoder (
    .funct  (funct),
    .alu_op (dec_alu_op),
    .legal  (funct_legal)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state and control-word decode
  always_comb begin
    state_d      = S_FETCH;
    ctrl         = '0;
    ctrl.alu_op  = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        state_d        = S_DECODE;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (funct_legal) state_d = S_EXECUTE;
            else             ctrl.illegal_op = 1'b1;
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_ADDI: state_d = S_ADDIEX;
          OP_J:    state_d = S_JUMP;
          default: ctrl.illegal_op = 1'b1;
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        state_d        = (state_q == S_ADDIEX) ? S_ADDIWB
                       : (opcode == OP_LW)     ? S_MEMRD : S_MEMWR;
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        state_d   = S_MEMWB;
        ctrl.iord = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_EXECUTE: begin
        state_d        = S_ALUWB;
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = dec_alu_op;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      // Unused encodings recover to FETCH, driving DECODE-like outputs
      default: ctrl.alu_src_b = SRCB_IMM_SH2;
    endcase

    // Hold all enables off while reset is asserted
    if (!rst_n) begin
      ctrl           = '0;
      ctrl.alu_op    = ALU_ADD;
      ctrl.alu_src_b = SRCB_FOUR;
    end
  end

  assign pc_en      = ctrl.pc_write | (ctrl.branch & zero);
  assign ir_write   = ctrl.ir_write;
  assign mem_write  = ctrl.mem_write;
  assign reg_write  = ctrl.reg_write;
  assign iord       = ctrl.iord;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_dst    = ctrl.reg_dst;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_src     = ctrl.pc_src;
  assign illegal_op = ctrl.illegal_op;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Testbench for mc_control_unit: directed and random instructions checked
// cycle by cycle against an instruction-level reference model.
module tb_mc_control_unit;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_en, ir_write, mem_write, reg_write, iord, mem_to_reg;
  logic       reg_dst, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_op;
  logic [3:0] state_dbg;

  int total = 0;
  int bad   = 0;
  int seq[$];

  mc_control_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .pc_en      (pc_en),
    .ir_write   (ir_write),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .iord       (iord),
    .mem_to_reg (mem_to_reg),
    .reg_dst    (reg_dst),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .illegal_op (illegal_op),
    .state_dbg  (state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [15:0] got_bundle;
  assign got_bundle = {pc_en, ir_write, mem_write, reg_write, iord, mem_to_reg,
                       reg_dst, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit legal_funct(input logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // State visit list of one instruction, starting with FETCH
  task automatic build_seq(input logic [5:0] op, input logic [5:0] fn);
    seq = '{0, 1};
    case (op)
      6'b100011: seq = '{0, 1, 2, 3, 4};
      6'b101011: seq = '{0, 1, 2, 5};
      6'b000000: if (legal_funct(fn)) seq = '{0, 1, 6, 7};
      6'b000100: seq = '{0, 1, 8};
      6'b001000: seq = '{0, 1, 9, 10};
      6'b000010: seq = '{0, 1, 11};
      default:   ;
    endcase
  endtask

  // Expected output bundle for a state, from the output table
  function automatic logic [15:0] exp_bundle(input int st, input logic [5:0] fn,
                                             input logic z, input logic ill,
                                             input logic in_rst);
    logic pe, irw, mw, rw, io, m2r, rd, sa, il;
    logic [1:0] sb, ps;
    logic [2:0] ao;
    {pe, irw, mw, rw, io, m2r, rd, sa, il} = '0;
    sb = 2'b00; ps = 2'b00; ao = 3'b010;
    if (in_rst) sb = 2'b01;
    else begin
      case (st)
        0:  begin irw = 1; sb = 2'b01; pe = 1; end
        1:  begin sb = 2'b11; il = ill; end
        2, 9: begin sa = 1; sb = 2'b10; end
        3:  io = 1;
        4:  begin m2r = 1; rw = 1; end
        5:  begin io = 1; mw = 1; end
        6:  begin sa = 1; ao = funct_alu(fn); end
        7:  begin rd = 1; rw = 1; end
        8:  begin sa = 1; ao = 3'b110; ps = 2'b01; pe = z; end
        10: rw = 1;
        11: begin ps = 2'b10; pe = 1; end
        default: ;
      endcase
    end
    return {pe, irw, mw, rw, io, m2r, rd, sa, sb, ao, ps, il};
  endfunction

  // Runs one instruction from FETCH; fields are only valid in the cycles
  // that may sample them, random elsewhere. abort_at pulses reset at step k.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int abort_at);
    logic ill;
    int   st;
    build_seq(op, fn);
    ill = (seq.size() == 2);
    for (int k = 0; k < seq.size(); k++) begin
      st     = seq[k];
      opcode = (st == 1 || st == 2) ? op : 6'($urandom);
      funct  = (st == 1 || st == 6) ? fn : 6'($urandom);
      zero   = (st == 8) ? z : 1'($urandom);
      #1;
      check($sformatf("state op=%b fn=%b k=%0d", op, fn, k), 32'(state_dbg), 32'(st));
      check($sformatf("outs op=%b fn=%b k=%0d z=%b", op, fn, k, z), 32'(got_bundle),
            32'(exp_bundle(st, fn, z, ill, 1'b0)));
      if (k == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        check("abort state", 32'(state_dbg), 32'd0);
        check("abort outs", 32'(got_bundle), 32'(exp_bundle(0, fn, z, 1'b0, 1'b1)));
        #2 rst_n = 1'b1;
        #1;
        check("abort release outs", 32'(got_bundle), 32'(exp_bundle(0, fn, z, 1'b0, 1'b0)));
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [5:0] op, fn;
    int         pick;
    rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0;
    #3;
    check("reset state", 32'(state_dbg), 32'd0);
    check("reset outs", 32'(got_bundle), 32'(exp_bundle(0, 6'd0, 1'b0, 1'b0, 1'b1)));
    opcode = 6'b101011; zero = 1'b1;
    @(posedge clk); #1;
    check("reset hold state", 32'(state_dbg), 32'd0);
    check("reset hold outs", 32'(got_bundle), 32'(exp_bundle(0, 6'd0, 1'b0, 1'b0, 1'b1)));
    #3 rst_n = 1'b1;

    // Directed cases
    run_instr(6'b100011, 6'b000000, 1'b0, -1);  // lw
    run_instr(6'b000000, 6'b100010, 1'b0, -1);  // sub
    run_instr(6'b000000, 6'b101010, 1'b0, -1);  // slt
    run_instr(6'b000000, 6'b100100, 1'b0, -1);  // and
    run_instr(6'b000000, 6'b100101, 1'b0, -1);  // or
    run_instr(6'b000100, 6'b000000, 1'b1, -1);  // beq taken
    run_instr(6'b000100, 6'b000000, 1'b0, -1);  // beq not taken
    run_instr(6'b111111, 6'b100000, 1'b0, -1);  // bad opcode
    run_instr(6'b000000, 6'b000000, 1'b0, -1);  // bad funct
    run_instr(6'b001000, 6'b000000, 1'b0, -1);  // addi
    run_instr(6'b000010, 6'b000000, 1'b0, -1);  // j
    run_instr(6'b101011, 6'b000000, 1'b0, 3);   // sw, reset in MEMWR
    run_instr(6'b101011, 6'b000000, 1'b0, -1);  // sw after release

    // Random instruction stream
    for (int n = 0; n < 120; n++) begin
      pick = $urandom_range(0, 7);
      case (pick)
        0: op = 6'b100011;
        1: op = 6'b101011;
        2, 3: op = 6'b000000;
        4: op = 6'b000100;
        5: op = 6'b001000;
        6: op = 6'b000010;
        default: op = 6'($urandom);
      endcase
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0: fn = 6'b100000;
          1: fn = 6'b100010;
          2: fn = 6'b100100;
          3: fn = 6'b100101;
          default: fn = 6'b101010;
        endcase
      end else fn = 6'($urandom);
      run_instr(op, fn, 1'($urandom), ($urandom_range(0, 15) == 0) ? 1 : -1);
    end

    opcode = '0; funct = '0; zero = 1'b0;
    #1;
    check("final state", 32'(state_dbg), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
